mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   owner_e   : which port owns the access currently in flight (its response is due this cycle)
//   Func3Word : func3 encoding used for instruction fetches (full 32-bit word)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  localparam logic [2:0] Func3Word = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory (1-cycle read latency) between an
// instruction fetch port (if_*) and a data load/store port (d_*).
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   if_req/if_addr     : fetch request and byte address; if_ack/if_rdata one cycle after issue
//   d_req/d_we/d_addr/
//   d_wdata/d_func3    : data request; d_ack/d_rdata one cycle after issue
//   mem_*              : shared memory port; mem_en marks an issue this cycle
// Grant is combinational; data wins contested cycles until STARVE_LIMIT consecutive contested
// data wins have accumulated, after which fetch is granted once.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  // owner_q records the last grant; it is also the in-flight owner whose ack is this cycle
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            if_elig, d_elig, grant_if, grant_d;

  assign if_ack   = (owner_q == OwnIf);
  assign d_ack    = (owner_q == OwnD);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    // A port cannot reissue in the cycle its own response is returned.
    if_elig  = if_req & ~if_ack;
    d_elig   = d_req & ~d_ack;
    if (!reset) begin
      if (if_elig && d_elig) begin
        if (starve_q == Limit) grant_if = 1'b1;
        else                   grant_d  = 1'b1;
      end else begin
        grant_if = if_elig;
        grant_d  = d_elig;
      end
    end

    starve_d = starve_q;
    if (grant_if)                starve_d = '0;
    else if (grant_d && if_elig) starve_d = starve_q + CntW'(1);

    owner_d = OwnNone;
    if (grant_if)     owner_d = OwnIf;
    else if (grant_d) owner_d = OwnD;
  end

  always_comb begin
    mem_en    = grant_if | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = grant_d ? d_addr : if_addr;
    mem_wdata = d_wdata;
    mem_func3 = grant_d ? d_func3 : Func3Word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= OwnNone;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-level reference model predicts each grant from the
// arbitration rules and queues the expected response; a separate monitor checks every ack.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_func3;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_func3  (d_func3),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_func3(mem_func3),
    .mem_rdata(mem_rdata)
  );

  // Word-addressed memory behind the arbiter, plus the model's own shadow copy of its contents.
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        rd_q <= mem[mem_addr[9:2]];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: owner 0=none 1=fetch 2=data, response due the cycle after a grant.
  int m_owner = 0;
  int m_starve = 0;

  always @(negedge clock) begin
    bit   ie, de;
    int   g;
    exp_t e;
    if (reset) begin
      m_owner  = 0;
      m_starve = 0;
      exp_q.delete();
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_acks", {30'b0, if_ack, d_ack}, 0);
      chk("rst_starve", {29'b0, dut.starve_q}, 0);
    end else begin
      ie = if_req && (m_owner != 1);
      de = d_req && (m_owner != 2);
      if (ie && de)  g = (m_starve == 4) ? 1 : 2;
      else if (de)   g = 2;
      else if (ie)   g = 1;
      else           g = 0;
      chk("starve_cnt", {29'b0, dut.starve_q}, m_starve);
      chk("mem_en", {31'b0, mem_en}, (g != 0) ? 1 : 0);
      chk("mem_we", {31'b0, mem_we}, (g == 2 && d_we) ? 1 : 0);
      e.cyc = cyc + 1;
      if (g == 1) begin
        chk("fetch_addr", mem_addr, if_addr);
        chk("fetch_func3", {29'b0, mem_func3}, 32'd2);
        e.is_d = 1'b0; e.chk_data = 1'b1; e.data = shadow[if_addr[9:2]];
        exp_q.push_back(e);
      end else if (g == 2) begin
        chk("data_addr", mem_addr, d_addr);
        chk("data_func3", {29'b0, mem_func3}, {29'b0, d_func3});
        e.is_d = 1'b1;
        if (d_we) begin
          chk("data_wdata", mem_wdata, d_wdata);
          shadow[d_addr[9:2]] = d_wdata;
          e.chk_data = 1'b0; e.data = '0;
        end else begin
          e.chk_data = 1'b1; e.data = shadow[d_addr[9:2]];
        end
        exp_q.push_back(e);
      end
      if (g == 1)            m_starve = 0;
      else if (g == 2 && ie) m_starve++;
      m_owner = g;
    end
  end

  // Monitor: consumes one expected response per observed ack.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (if_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_ack", {30'b0, if_ack, d_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", {31'b0, d_ack}, {31'b0, e.is_d});
          chk("ack_single", {31'b0, if_ack & d_ack}, 0);
          chk("ack_cycle", cyc, e.cyc);
          if (e.chk_data) chk(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_ack", {31'b0, if_ack | d_ack}, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_func3 = f3;
  endtask

  // Keep stepping, releasing each request once its ack is seen, until both ports are idle.
  task automatic drain();
    for (int i = 0; i < 50 && (if_req || d_req); i++) begin
      step();
      if (if_ack) if_req = 1'b0;
      if (d_ack)  d_req  = 1'b0;
    end
    if (if_req || d_req) begin
      chk("drain_timeout", {30'b0, if_req, d_req}, 0);
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  task automatic rand_cycle(input int pif, input int pd);
    step();
    if (!if_req || if_ack) begin
      if_req  = ($urandom_range(99) < pif);
      if_addr = {22'b0, 8'($urandom_range(255)), 2'b00};
    end
    if (!d_req || d_ack) begin
      d_req   = ($urandom_range(99) < pd);
      d_we    = 1'($urandom_range(1));
      d_addr  = {22'b0, 8'($urandom_range(255)), 2'b00};
      d_wdata = $urandom;
      d_func3 = 3'($urandom_range(7));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    rd_q  = '0;
    reset = 1'b1;
    // Requests held during reset must not issue; both are served right after release.
    if_req = 1'b1; if_addr = 32'h10;
    set_d(1'b0, 32'h100, 32'h0, 3'b010);
    repeat (3) step();
    reset = 1'b0;
    drain();

    // Lone fetcher holding its request: issue, ack, issue, ...
    step();
    if_req = 1'b1; if_addr = 32'h10;
    repeat (6) step();
    drain();

    // Store then load the same word.
    step();
    set_d(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
    drain();
    step();
    set_d(1'b0, 32'h100, 32'h0, 3'b010);
    drain();

    // Both ports held: accesses alternate back to back.
    step();
    if_req = 1'b1; if_addr = 32'h24;
    set_d(1'b0, 32'h80, 32'h0, 3'b000);
    repeat (12) step();
    drain();

    // Reset during a data access: the access is dropped, the held request reissues after release.
    step();
    set_d(1'b0, 32'h40, 32'h0, 3'b010);
    @(negedge clock);
    #2 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    drain();

    for (int i = 0; i < 2000; i++) begin
      case (i / 500)
        0:       rand_cycle(90, 90);
        1:       rand_cycle(30, 80);
        2:       rand_cycle(80, 30);
        default: rand_cycle(50, 50);
      endcase
    end
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
